// File: rtl/serial_frame_pkg.sv
// Shared definitions for the framed serial link (receiver and transmitter side).
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } RX_STATE_T;

    localparam logic START_BIT  = 1'b1;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_shift_in.sv
// W-bit shift register with enable; new bits enter at the LSB so the first bit ends up at the MSB.
module serial_shift_in #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);

    generate
        if (W == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (reset)
                    q <= '0;
                else if (en)
                    q <= din;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (reset)
                    q <= '0;
                else if (en)
                    q <= {q[W-2:0], din};
            end
        end
    endgenerate

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, N data bits MSB first, optional even parity bit.
// Optional parity checking is enabled by defining SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_en,
    input  logic         serial_in,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    input  logic         data_ready,
    output logic         overrun
`ifdef SERIAL_FRAME_RX_PARITY_EN
    ,
    output logic         parity_err
`endif
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Without parity the final data bit is taken straight from the line, so one bit less is stored.
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int SW = N;
`else
    localparam int SW = N - 1;
`endif

    RX_STATE_T       state;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   shift_q;
    logic            shift_en;
    logic            commit;
    logic [N-1:0]    commit_word;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic            commit_perr;
`endif

    assign shift_en = bit_en && (state == DATA);

    serial_shift_in #(.W(SW)) u_shift (
        .clk   (clk),
        .reset (reset),
        .en    (shift_en),
        .din   (serial_in),
        .q     (shift_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (bit_en) begin
            case (state)
                IDLE: begin
                    if (serial_in == START_BIT) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        commit = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        commit_word = shift_q;
        commit_perr = serial_in ^ (^shift_q);
        if (bit_en && state == PARITY)
            commit = 1'b1;
`else
        commit_word = {shift_q, serial_in};
        if (bit_en && state == DATA && cnt == LAST)
            commit = 1'b1;
`endif
    end

    // A commit always wins over a plain accept; a full, unaccepted buffer drops the new word.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (commit) begin
            if (!data_valid || data_ready) begin
                data_out   <= commit_word;
                data_valid <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                parity_err <= commit_perr;
`endif
            end else begin
                overrun <= 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx; parity scenarios build when SERIAL_FRAME_RX_PARITY_EN is defined.
module tb_serial_frame_rx;
    import serial_frame_pkg::*;

    localparam int N = 16;

    logic         clk;
    logic         reset;
    logic         bit_en;
    logic         serial_in;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic         overrun;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic         parity_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_word;

    serial_frame_rx #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun)
`ifdef SERIAL_FRAME_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every task is entered and left 1 time unit after a rising edge.
    task automatic drive_bit(input logic b, input int gap, input logic rdy);
        bit_en    = 1'b0;
        serial_in = IDLE_LEVEL;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bit_en     = 1'b1;
        serial_in  = b;
        data_ready = rdy;
        @(posedge clk);
        #1;
        bit_en     = 1'b0;
        serial_in  = IDLE_LEVEL;
        data_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [N-1:0] word, input int gap, input logic rdy_last,
                              input logic flip_par);
        logic last;
        drive_bit(START_BIT, gap, 1'b0);
        for (int i = N - 1; i >= 0; i--) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            last = 1'b0;
`else
            last = (i == 0);
`endif
            drive_bit(word[i], gap, last ? rdy_last : 1'b0);
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        drive_bit((^word) ^ flip_par, gap, rdy_last);
`else
        if (flip_par) $display("[TB] note: parity flip ignored, parity disabled");
`endif
    endtask

    task automatic accept_word();
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", data_valid); end
        checks++; if (data_out !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0000", data_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity: got %b expected 0", parity_err); end
`endif
    endtask

    task automatic test_basic();
        exp_q.push_back(16'hA5C3);
        send_frame(16'hA5C3, 0, 1'b0, 1'b0);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", data_valid); end
        exp_word = (exp_q.size() > 0) ? exp_q[0] : 'x;
        checks++; if (data_out !== exp_word) begin errors++; $display("[TB] FAIL basic_data: got %h expected %h", data_out, exp_word); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL basic_overrun: got %b expected 0", overrun); end
        accept_word();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_accept_valid: got %b expected 0", data_valid); end
        checks++; if (data_out !== 16'hA5C3) begin errors++; $display("[TB] FAIL basic_hold_data: got %h expected a5c3", data_out); end
    endtask

    task automatic test_overrun();
        exp_q.push_back(16'h1234);
        send_frame(16'h1234, 0, 1'b0, 1'b0);
        send_frame(16'hFFFF, 0, 1'b0, 1'b0);
        exp_word = (exp_q.size() > 0) ? exp_q[0] : 'x;
        checks++; if (data_out !== exp_word) begin errors++; $display("[TB] FAIL overrun_data: got %h expected %h", data_out, exp_word); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("[TB] FAIL overrun_valid: got %b expected 1", data_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_flag: got %b expected 1", overrun); end
        accept_word();
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_sticky: got %b expected 1", overrun); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL overrun_accept: got %b expected 0", data_valid); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(16'h0F0F);
        send_frame(16'h0F0F, 0, 1'b0, 1'b0);
        // The old word is consumed in the same cycle the new one lands.
        void'(exp_q.pop_front());
        exp_q.push_back(16'h00F0);
        send_frame(16'h00F0, 0, 1'b1, 1'b0);
        exp_word = (exp_q.size() > 0) ? exp_q[0] : 'x;
        checks++; if (data_out !== exp_word) begin errors++; $display("[TB] FAIL b2b_data: got %h expected %h", data_out, exp_word); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid: got %b expected 1", data_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun); end
        accept_word();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept: got %b expected 0", data_valid); end
    endtask

    task automatic test_idle_gaps();
        for (int i = 0; i < 20; i++) begin
            drive_bit(IDLE_LEVEL, 0, 1'b0);
            checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid[%0d]: got %b expected 0", i, data_valid); end
        end
        exp_q.push_back(16'h8001);
        send_frame(16'h8001, 3, 1'b0, 1'b0);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("[TB] FAIL gap_valid: got %b expected 1", data_valid); end
        exp_word = (exp_q.size() > 0) ? exp_q[0] : 'x;
        checks++; if (data_out !== exp_word) begin errors++; $display("[TB] FAIL gap_data: got %h expected %h", data_out, exp_word); end
        accept_word();
    endtask

    task automatic test_reset_midframe();
        exp_q.push_back(16'hC3C3);
        send_frame(16'hC3C3, 0, 1'b0, 1'b0);
        drive_bit(START_BIT, 0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(1'b1, 0, 1'b0);
        reset     = 1'b1;
        bit_en    = 1'b1;
        serial_in = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bit_en    = 1'b0;
        serial_in = IDLE_LEVEL;
        exp_q.delete();
        checks++; if (data_out !== '0) begin errors++; $display("[TB] FAIL midreset_data: got %h expected 0000", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", data_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL midreset_overrun: got %b expected 0", overrun); end
        exp_q.push_back(16'h5555);
        send_frame(16'h5555, 0, 1'b0, 1'b0);
        exp_word = (exp_q.size() > 0) ? exp_q[0] : 'x;
        checks++; if (data_out !== exp_word) begin errors++; $display("[TB] FAIL midreset_next: got %h expected %h", data_out, exp_word); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("[TB] FAIL midreset_next_valid: got %b expected 1", data_valid); end
        accept_word();
    endtask

`ifdef SERIAL_FRAME_RX_PARITY_EN
    task automatic test_parity();
        exp_q.push_back(16'h0007);
        send_frame(16'h0007, 0, 1'b0, 1'b0);
        exp_word = (exp_q.size() > 0) ? exp_q[0] : 'x;
        checks++; if (data_out !== exp_word) begin errors++; $display("[TB] FAIL par_good_data: got %h expected %h", data_out, exp_word); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL par_good_err: got %b expected 0", parity_err); end
        accept_word();
        exp_q.push_back(16'h0007);
        send_frame(16'h0007, 0, 1'b0, 1'b1);
        exp_word = (exp_q.size() > 0) ? exp_q[0] : 'x;
        checks++; if (data_valid !== 1'b1) begin errors++; $display("[TB] FAIL par_bad_valid: got %b expected 1", data_valid); end
        checks++; if (data_out !== exp_word) begin errors++; $display("[TB] FAIL par_bad_data: got %h expected %h", data_out, exp_word); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("[TB] FAIL par_bad_err: got %b expected 1", parity_err); end
        accept_word();
    endtask
`endif

    initial begin
        reset      = 1'b1;
        bit_en     = 1'b0;
        serial_in  = IDLE_LEVEL;
        data_ready = 1'b0;
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_idle_gaps();
        test_reset_midframe();
`ifdef SERIAL_FRAME_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
